spike_event_fifo: RTL and testbench

Downstream consumer of the neuron core's `spike` output: detects rising edges of the spike line, stamps each event with a free-running cycle counter, and buffers the stamps in a small FIFO. A valid/ready handshake drains the FIFO to whatever reads spike times, such as an output serializer or pin mux. Overflow is counted, never silently lost.

---
 rtl/spike_event_fifo.sv | 88 ++++++++
 tb/tb_spike_event_fifo.sv | 131 +++++++++++++
 2 files changed

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: timestamps rising edges of spike into a small valid/ready FIFO, counting overflow drops.
// Define SPIKE_TS_DELTA_EN to store inter-spike intervals instead of absolute timestamps.
module spike_event_fifo #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spike,
  input  logic                    clr_drop,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [TS_W-1:0]         out_ts,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    drop_flag,
  output logic [7:0]              drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_mem [DEPTH];
  logic            r_spike_d;
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_cnt;
  logic            r_flag;
  logic [7:0]      r_drop;
  logic            w_event;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_lost;
  logic [TS_W-1:0] w_entry;
  always_comb begin
    w_event    = spike & ~r_spike_d;
    w_full     = r_cnt == (AW+1)'(DEPTH);
    w_pop      = out_valid & out_ready;
    w_push     = w_event & (~w_full | w_pop);
    w_lost     = w_event & w_full & ~w_pop;
    out_valid  = r_cnt != '0;
    out_ts     = out_valid ? r_mem[r_rd] : '0;
    fifo_count = r_cnt;
    drop_flag  = r_flag;
    drop_cnt   = r_drop;
  end
`ifdef SPIKE_TS_DELTA_EN
  logic [TS_W-1:0] r_last;
  // last_ts follows only written events so stored deltas sum to time between stored spikes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_last <= '0;
    else if (w_push) r_last <= r_ts;
  end
  always_comb w_entry = r_ts - r_last;
`else
  always_comb w_entry = r_ts;
`endif
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_entry;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts      <= '0;
      r_spike_d <= 1'b0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
    end else begin
      r_ts      <= r_ts + TS_W'(1);
      r_spike_d <= spike;
      r_wr      <= w_push ? r_wr + AW'(1) : r_wr;
      r_rd      <= w_pop ? r_rd + AW'(1) : r_rd;
      r_cnt     <= (w_push & ~w_pop) ? r_cnt + (AW+1)'(1) :
                   (w_pop & ~w_push) ? r_cnt - (AW+1)'(1) : r_cnt;
    end
  end
  // a drop coinciding with clear survives as the first count after the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag <= 1'b0;
      r_drop <= '0;
    end else if (clr_drop) begin
      r_flag <= w_lost;
      r_drop <= {7'd0, w_lost};
    end else if (w_lost) begin
      r_flag <= 1'b1;
      r_drop <= (r_drop == 8'hFF) ? r_drop : r_drop + 8'd1;
    end
  end
endmodule

// File: tb/tb_spike_event_fifo.sv
// tb_spike_event_fifo: randomized stimulus against a queue-based reference model with a decoupled output monitor.
module tb_spike_event_fifo;
  localparam int TS_W = 6;
  localparam int DEPTH = 4;
  localparam int M = 1 << TS_W;
  logic clk = 0;
  logic reset = 1;
  logic spike = 0;
  logic clr_drop = 0;
  logic out_ready = 0;
  logic out_valid;
  logic [TS_W-1:0] out_ts;
  logic [$clog2(DEPTH):0] fifo_count;
  logic drop_flag;
  logic [7:0] drop_cnt;
  int checks = 0;
  int failures = 0;
  int sb[$];
  int m_ts, m_cnt, m_drop, m_last;
  bit m_sd, m_flag;
  bit hold_prev;
  logic [TS_W-1:0] prev_ts;
  spike_event_fifo #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .spike(spike), .clr_drop(clr_drop), .out_ready(out_ready),
    .out_valid(out_valid), .out_ts(out_ts), .fifo_count(fifo_count),
    .drop_flag(drop_flag), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask
  always @(negedge clk) begin
    bit ev, pop, lost;
    if (reset) begin
      m_ts = 0; m_sd = 0; m_cnt = 0; m_drop = 0; m_last = 0; m_flag = 0;
      sb.delete();
    end else begin
      chk("out_valid", out_valid, m_cnt != 0);
      chk("fifo_count", fifo_count, m_cnt);
      chk("drop_flag", drop_flag, m_flag);
      chk("drop_cnt", drop_cnt, m_drop);
      ev = spike && !m_sd;
      pop = m_cnt > 0 && out_ready;
      lost = 0;
      if (ev) begin
        if (m_cnt < DEPTH || pop) begin
`ifdef SPIKE_TS_DELTA_EN
          sb.push_back((m_ts - m_last + M) % M);
`else
          sb.push_back(m_ts);
`endif
          m_last = m_ts;
          m_cnt++;
        end else lost = 1;
      end
      if (pop) m_cnt--;
      if (clr_drop) begin
        m_drop = lost;
        m_flag = lost;
      end else if (lost) begin
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        m_flag = 1;
      end
      m_sd = spike;
      m_ts = (m_ts + 1) % M;
    end
  end
  always @(negedge clk) begin
    if (reset) hold_prev = 0;
    else begin
      if (hold_prev) chk("out_ts_hold", out_ts, prev_ts);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_underflow at %0t: got out_ts %0d expected no entry", $time, out_ts);
        end else chk("out_ts", out_ts, sb.pop_front());
      end
      hold_prev = out_valid && !out_ready;
      prev_ts = out_ts;
    end
  end
  initial begin
    int rdy_pct;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    for (int p = 0; p < 16; p++) begin
      if (p % 4 == 3) begin
        @(posedge clk);
        #1 reset = 1;
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_drop", drop_cnt, 0);
        @(posedge clk);
        #1 reset = 0;
      end
      rdy_pct = (p % 4 == 1) ? 5 : (p % 4 == 2) ? 50 : 90;
      for (int c = 0; c < 150; c++) begin
        @(posedge clk);
        #1;
        out_ready = $urandom_range(99) < rdy_pct;
        if (p % 4 == 2) spike = ($urandom_range(3) == 0) ? ~spike : spike;
        else spike = $urandom_range(1);
        clr_drop = $urandom_range(39) == 0;
      end
    end
    out_ready = 0;
    clr_drop = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1 spike = ~spike;
    end
    @(posedge clk);
    #1 clr_drop = 1;
    spike = 1;
    @(posedge clk);
    #1 clr_drop = 0;
    spike = 0;
    out_ready = 1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1 chk("drain_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
